// File: rtl/mrail_pkg.sv
// Shared multi-rail (1-of-N) codeword helpers for NCL-style pipelines.
// Words are zero-extended to MaxRails so the helpers work for any rail count.
package mrail_pkg;

  localparam int unsigned MaxRails = 64;
  localparam logic [MaxRails-1:0] NullWord = '0;

  function automatic int unsigned popcount(input logic [MaxRails-1:0] w);
    int unsigned n;
    n = 0;
    for (int i = 0; i < MaxRails; i++) n += int'(w[i]);
    return n;
  endfunction

  function automatic logic is_data(input logic [MaxRails-1:0] w);
    return popcount(w) == 1;
  endfunction

  function automatic logic is_multi(input logic [MaxRails-1:0] w);
    return popcount(w) >= 2;
  endfunction

  // TH22 hysteresis: set when x and en agree high, clear when both low, else hold.
  function automatic logic th22_next(input logic x, input logic en, input logic z);
    return (x & en) | (z & (x | en));
  endfunction

endpackage

// File: rtl/mrail_pipeline_n_stage.sv
// One multi-rail pipeline stage: per-rail TH22 register plus completion detect.
module mrail_stage
  import mrail_pkg::*;
#(
  parameter int unsigned RAILS = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [RAILS-1:0] x_i,
  input  logic             en_i,
  output logic [RAILS-1:0] z_o,
  output logic             comp_o
);

  logic [RAILS-1:0] z_d, z_q;

  always_comb begin
    z_d = z_q;
    for (int r = 0; r < RAILS; r++) z_d[r] = th22_next(x_i[r], en_i, z_q[r]);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) z_q <= NullWord[RAILS-1:0];
    else         z_q <= z_d;
  end

  assign z_o    = z_q;
  assign comp_o = |z_q;

endmodule

// File: rtl/mrail_pipeline_n.sv
// Parametrised clocked model of a DEPTH-stage 1-of-RAILS NCL pipeline with
// multi-hot error flag, output DATA wavefront counter and occupancy report.
module mrail_pipeline_n
  import mrail_pkg::*;
#(
  parameter int unsigned RAILS = 4,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic                       clk,
  input  logic                       init_n,
  input  logic [RAILS-1:0]           in_rails,
  output logic                       in_ack,
  output logic [RAILS-1:0]           out_rails,
  input  logic                       out_ack,
  input  logic                       err_clr,
  output logic                       err_multi,
  output logic [CNT_W-1:0]           wave_cnt,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);

  localparam int unsigned OccW = $clog2(DEPTH + 1);

  logic [RAILS-1:0] x_w  [DEPTH];
  logic [RAILS-1:0] z_w  [DEPTH];
  logic [DEPTH-1:0] en_w;
  logic [DEPTH-1:0] stage_comp;
  logic [DEPTH:0]   comp;

  assign comp = {out_ack, stage_comp};

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    if (i == 0) begin : g_first
      assign x_w[i] = in_rails;
    end else begin : g_rest
      assign x_w[i] = z_w[i-1];
    end
    assign en_w[i] = ~comp[i+1];

    mrail_stage #(
      .RAILS (RAILS)
    ) u_stage (
      .clk_i  (clk),
      .rst_ni (init_n),
      .x_i    (x_w[i]),
      .en_i   (en_w[i]),
      .z_o    (z_w[i]),
      .comp_o (stage_comp[i])
    );
  end

  // Next completion of the last stage, so the counter steps on the same edge
  // that the output turns non-NULL.
  logic last_next;
  always_comb begin
    last_next = 1'b0;
    for (int r = 0; r < RAILS; r++) begin
      last_next |= th22_next(x_w[DEPTH-1][r], en_w[DEPTH-1], z_w[DEPTH-1][r]);
    end
  end

  logic             err_d, err_q;
  logic [CNT_W-1:0] wave_d, wave_q;

  always_comb begin
    err_d = err_q;
    if (err_clr) err_d = 1'b0;
    if (is_multi(MaxRails'(in_rails))) err_d = 1'b1;
  end

  always_comb begin
    wave_d = wave_q;
    if (!stage_comp[DEPTH-1] && last_next) wave_d = wave_q + 1'b1;
  end

  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) begin
      err_q  <= 1'b0;
      wave_q <= '0;
    end else begin
      err_q  <= err_d;
      wave_q <= wave_d;
    end
  end

  logic [OccW-1:0] occ;
  always_comb begin
    occ = '0;
    for (int i = 0; i < DEPTH; i++) occ = occ + OccW'(stage_comp[i]);
  end

  assign in_ack    = comp[0];
  assign out_rails = z_w[DEPTH-1];
  assign err_multi = err_q;
  assign wave_cnt  = wave_q;
  assign occupancy = occ;

endmodule

// File: tb/tb_mrail_pipeline_n.sv
// Self-checking bench for mrail_pipeline_n: a 4x4 instance plus a 2-rail,
// 1-stage, 3-bit-counter instance; handshake streams checked by a token queue.
module tb_mrail_pipeline_n;

  logic        clk = 1'b0;
  logic        init_n;
  logic [3:0]  in_rails, out_rails;
  logic        in_ack, out_ack, err_clr, err_multi;
  logic [15:0] wave_cnt;
  logic [2:0]  occupancy;

  logic [1:0]  in2, out2;
  logic        in_ack2, out_ack2, err_clr2, err2;
  logic [2:0]  wave2;
  logic [0:0]  occ2;

  int n_checks = 0;
  int n_fail   = 0;

  logic [3:0] src_q[$];
  logic [3:0] got_q[$];

  always #5 clk = ~clk;

  mrail_pipeline_n #(.RAILS(4), .DEPTH(4), .CNT_W(16)) dut (
    .clk(clk), .init_n(init_n), .in_rails(in_rails), .in_ack(in_ack),
    .out_rails(out_rails), .out_ack(out_ack), .err_clr(err_clr),
    .err_multi(err_multi), .wave_cnt(wave_cnt), .occupancy(occupancy)
  );

  mrail_pipeline_n #(.RAILS(2), .DEPTH(1), .CNT_W(3)) dut_small (
    .clk(clk), .init_n(init_n), .in_rails(in2), .in_ack(in_ack2),
    .out_rails(out2), .out_ack(out_ack2), .err_clr(err_clr2),
    .err_multi(err2), .wave_cnt(wave2), .occupancy(occ2)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic apply_reset();
    init_n   = 1'b0;
    in_rails = 4'b0100;
    out_ack  = 1'b0;
    err_clr  = 1'b0;
    in2      = 2'b00;
    out_ack2 = 1'b0;
    err_clr2 = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic release_reset();
    in_rails = 4'b0000;
    init_n   = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    apply_reset();
    n_checks++; if (out_rails !== 4'b0000) begin n_fail++;
      $display("FAIL reset_out: got %b want 0000", out_rails); end
    n_checks++; if (in_ack !== 1'b0) begin n_fail++;
      $display("FAIL reset_in_ack: got %b want 0", in_ack); end
    n_checks++; if (occupancy !== 3'd0) begin n_fail++;
      $display("FAIL reset_occ: got %0d want 0", occupancy); end
    n_checks++; if (wave_cnt !== 16'd0) begin n_fail++;
      $display("FAIL reset_wave: got %0d want 0", wave_cnt); end
    n_checks++; if (err_multi !== 1'b0) begin n_fail++;
      $display("FAIL reset_err: got %b want 0", err_multi); end
    n_checks++; if (out2 !== 2'b00 || wave2 !== 3'd0) begin n_fail++;
      $display("FAIL reset_small: out %b wave %0d want 00 0", out2, wave2); end
    release_reset();
  endtask

  task automatic test_latency();
    apply_reset();
    release_reset();
    in_rails = 4'b0100;
    @(negedge clk);
    n_checks++; if (in_ack !== 1'b1 || occupancy !== 3'd1) begin n_fail++;
      $display("FAIL lat_edge1: in_ack %b occ %0d want 1 1", in_ack, occupancy); end
    repeat (2) @(negedge clk);
    n_checks++; if (out_rails !== 4'b0000) begin n_fail++;
      $display("FAIL lat_edge3: out %b want 0000", out_rails); end
    @(negedge clk);
    n_checks++; if (out_rails !== 4'b0100) begin n_fail++;
      $display("FAIL lat_edge4: out %b want 0100", out_rails); end
    n_checks++; if (occupancy !== 3'd4) begin n_fail++;
      $display("FAIL lat_occ: got %0d want 4", occupancy); end
    n_checks++; if (wave_cnt !== 16'd1) begin n_fail++;
      $display("FAIL lat_wave: got %0d want 1", wave_cnt); end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    release_reset();
    in_rails = 4'b0010;
    repeat (4) @(posedge clk);
    #2 init_n = 1'b0;
    #1;
    n_checks++;
    if (out_rails !== 4'b0000 || in_ack !== 1'b0 || occupancy !== 3'd0 ||
        wave_cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL mid_reset: out %b ack %b occ %0d wave %0d want 0000 0 0 0",
               out_rails, in_ack, occupancy, wave_cnt);
    end
    @(negedge clk);
    release_reset();
  endtask

  task automatic test_backpressure();
    int  bad;
    bit  seen;
    apply_reset();
    release_reset();
    in_rails = 4'b0001;
    repeat (4) @(negedge clk);
    in_rails = 4'b0000;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (out_rails !== 4'b0001) bad++;
    end
    n_checks++; if (bad != 0) begin n_fail++;
      $display("FAIL bp_hold: %0d cycles lost 0001, want 0", bad); end
    n_checks++; if (occupancy !== 3'd1 || in_ack !== 1'b0) begin n_fail++;
      $display("FAIL bp_drain: occ %0d ack %b want 1 0", occupancy, in_ack); end
    in_rails = 4'b1000;
    @(negedge clk);
    in_rails = 4'b0000;
    repeat (5) @(negedge clk);
    n_checks++; if (occupancy !== 3'd2 || out_rails !== 4'b0001) begin n_fail++;
      $display("FAIL bp_stall: occ %0d out %b want 2 0001", occupancy, out_rails); end
    out_ack = 1'b1;
    seen = 0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      if (out_rails === 4'b0000) seen = 1;
    end
    n_checks++; if (!seen) begin n_fail++;
      $display("FAIL bp_null: out %b want 0000 within 10 cycles", out_rails); end
    out_ack = 1'b0;
    seen = 0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      if (out_rails !== 4'b0000) seen = 1;
    end
    n_checks++; if (!seen || out_rails !== 4'b1000) begin n_fail++;
      $display("FAIL bp_next: out %b want 1000", out_rails); end
    n_checks++; if (wave_cnt !== 16'd2) begin n_fail++;
      $display("FAIL bp_wave: got %0d want 2", wave_cnt); end
  endtask

  // Four-phase source and consumer with random pacing; src_q holds the tokens.
  task automatic test_stream(input string name);
    int idx, bad_occ;
    apply_reset();
    release_reset();
    got_q.delete();
    idx = 0;
    bad_occ = 0;
    for (int c = 0; c < 3000 && got_q.size() < src_q.size(); c++) begin
      @(negedge clk);
      if (occupancy > 3'd4) bad_occ++;
      if (!out_ack && out_rails !== 4'b0000 && $urandom_range(0, 2) != 0) begin
        got_q.push_back(out_rails);
        out_ack = 1'b1;
      end else if (out_ack && out_rails === 4'b0000 && $urandom_range(0, 2) != 0) begin
        out_ack = 1'b0;
      end
      if (in_rails !== 4'b0000 && in_ack) begin
        in_rails = 4'b0000;
      end else if (in_rails === 4'b0000 && !in_ack && idx < src_q.size() &&
                   $urandom_range(0, 2) != 0) begin
        in_rails = src_q[idx];
        idx++;
      end
    end
    n_checks++; if (got_q.size() != src_q.size()) begin n_fail++;
      $display("FAIL %s_count: got %0d tokens want %0d", name, got_q.size(), src_q.size()); end
    for (int k = 0; k < got_q.size() && k < src_q.size(); k++) begin
      n_checks++; if (got_q[k] !== src_q[k]) begin n_fail++;
        $display("FAIL %s_tok%0d: got %b want %b", name, k, got_q[k], src_q[k]); end
    end
    n_checks++; if (wave_cnt !== 16'(src_q.size())) begin n_fail++;
      $display("FAIL %s_wave: got %0d want %0d", name, wave_cnt, src_q.size()); end
    n_checks++; if (bad_occ != 0 || err_multi !== 1'b0) begin n_fail++;
      $display("FAIL %s_sanity: bad_occ %0d err %b want 0 0", name, bad_occ, err_multi); end
    out_ack = 1'b0;
  endtask

  task automatic test_error();
    apply_reset();
    release_reset();
    in_rails = 4'b0011;
    @(negedge clk);
    n_checks++; if (err_multi !== 1'b1 || in_ack !== 1'b1) begin n_fail++;
      $display("FAIL err_set: err %b ack %b want 1 1", err_multi, in_ack); end
    in_rails = 4'b0000;
    repeat (3) @(negedge clk);
    n_checks++; if (err_multi !== 1'b1) begin n_fail++;
      $display("FAIL err_sticky: got %b want 1", err_multi); end
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    n_checks++; if (err_multi !== 1'b0) begin n_fail++;
      $display("FAIL err_clear: got %b want 0", err_multi); end
    err_clr  = 1'b1;
    in_rails = 4'b0110;
    @(negedge clk);
    err_clr  = 1'b0;
    in_rails = 4'b0000;
    n_checks++; if (err_multi !== 1'b1) begin n_fail++;
      $display("FAIL err_set_wins: got %b want 1", err_multi); end
    @(negedge clk);
    n_checks++; if (err_multi !== 1'b1) begin n_fail++;
      $display("FAIL err_hold2: got %b want 1", err_multi); end
  endtask

  task automatic test_single_stage();
    logic [1:0] d;
    apply_reset();
    release_reset();
    for (int k = 0; k < 9; k++) begin
      d = ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10;
      in2 = d;
      @(negedge clk);
      n_checks++;
      if (out2 !== d || in_ack2 !== 1'b1 || occ2 !== 1'b1) begin n_fail++;
        $display("FAIL small_data%0d: out %b ack %b occ %0d want %b 1 1",
                 k, out2, in_ack2, occ2, d); end
      out_ack2 = 1'b1;
      in2 = 2'b00;
      @(negedge clk);
      n_checks++; if (out2 !== 2'b00 || in_ack2 !== 1'b0) begin n_fail++;
        $display("FAIL small_null%0d: out %b ack %b want 00 0", k, out2, in_ack2); end
      out_ack2 = 1'b0;
    end
    n_checks++; if (wave2 !== 3'd1) begin n_fail++;
      $display("FAIL small_wrap: got %0d want 1", wave2); end
  endtask

  initial begin
    logic [3:0] tok;
    test_reset();
    test_latency();
    test_reset_mid();
    test_backpressure();
    src_q.delete();
    src_q.push_back(4'b0001); src_q.push_back(4'b0010);
    src_q.push_back(4'b0100); src_q.push_back(4'b1000);
    src_q.push_back(4'b0001); src_q.push_back(4'b0010);
    src_q.push_back(4'b0100); src_q.push_back(4'b1000);
    test_stream("stream_fixed");
    src_q.delete();
    for (int k = 0; k < 24; k++) begin
      tok = 4'b0000;
      tok[$urandom_range(0, 3)] = 1'b1;
      src_q.push_back(tok);
    end
    test_stream("stream_rand");
    test_error();
    test_single_stage();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
